gate_stim_checker: RTL

GATE_STIM_CHECKER -- requirements
Module: gate_stim_checker

---
 rtl/gate_chk_pkg.sv | 21 ++
 rtl/gate_chk_hold_cnt.sv | 28 ++
 rtl/gate_stim_checker.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/gate_chk_pkg.sv
// Shared FSM encoding and sweep constants for gate_stim_checker.
// FAIL_MAP storage is enabled by defining GATE_CHK_FAILMAP_EN.
package gate_chk_pkg;

  localparam int unsigned VEC_COUNT = 4;
  localparam int unsigned ERR_MAX   = VEC_COUNT;
  localparam logic [1:0]  LAST_VEC  = 2'(VEC_COUNT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StFin
  } state_e;

  // Mismatch counter never wraps: one increment per vector at most.
  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v >= 3'(ERR_MAX)) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/gate_chk_hold_cnt.sv
// Per-vector hold timer: loadable down-counter with a zero flag.
// Part of gate_stim_checker (see GATE_CHK_FAILMAP_EN in the top for the optional feature).
module gate_chk_hold_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [Width-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - Width'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gate_stim_checker.sv
// Exhaustive stimulus/check sweep of a 2-input AND gate (vectors 00,01,10,11).
// Define GATE_CHK_FAILMAP_EN to build the per-vector FAIL_MAP; otherwise FAIL_MAP is tied to 0.
module gate_stim_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       Y,
  output logic       A,
  output logic       B,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [2:0] ERR_CNT,
  output logic [1:0] VEC_IDX,
  output logic [3:0] FAIL_MAP
);

  // Counter runs HOLD_CYCLES-1 down to 0, giving HOLD_CYCLES cycles in DRIVE.
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_e     r_state, w_state_next;
  logic [1:0] r_vec_idx, w_vec_next;
  logic       r_a, w_a_next;
  logic       r_b, w_b_next;
  logic [2:0] r_err_cnt, w_err_next;
  logic       r_done, w_done_next;
  logic       r_pass, w_pass_next;
  logic       w_hold_load, w_hold_dec, w_hold_zero;
  logic       w_start_sweep, w_mismatch;

  assign w_start_sweep = START && ((r_state == StIdle) || (r_state == StFin));
  assign w_mismatch    = (r_state == StSample) && (Y != (r_a & r_b));

  gate_chk_hold_cnt #(
    .Width (4)
  ) u_hold (
    .i_clk      (CLK),
    .i_rst_n    (RST_N),
    .i_load     (w_hold_load),
    .i_load_val (HOLD_LOAD),
    .i_dec      (w_hold_dec),
    .o_zero     (w_hold_zero)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= StIdle;
      r_vec_idx <= 2'd0;
      r_a       <= 1'b0;
      r_b       <= 1'b0;
      r_err_cnt <= 3'd0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_vec_idx <= w_vec_next;
      r_a       <= w_a_next;
      r_b       <= w_b_next;
      r_err_cnt <= w_err_next;
      r_done    <= w_done_next;
      r_pass    <= w_pass_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_vec_next   = r_vec_idx;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_err_next   = r_err_cnt;
    w_done_next  = r_done;
    w_pass_next  = r_pass;
    w_hold_load  = 1'b0;
    w_hold_dec   = 1'b0;
    unique case (r_state)
      StIdle, StFin: begin
        if (w_start_sweep) begin
          w_state_next = StDrive;
          w_vec_next   = 2'd0;
          w_a_next     = 1'b0;
          w_b_next     = 1'b0;
          w_err_next   = 3'd0;
          w_done_next  = 1'b0;
          w_pass_next  = 1'b0;
          w_hold_load  = 1'b1;
        end
      end
      StDrive: begin
        if (w_hold_zero) begin
          w_state_next = StSample;
        end else begin
          w_hold_dec = 1'b1;
        end
      end
      StSample: begin
        if (w_mismatch) begin
          w_err_next = sat_inc(r_err_cnt);
        end
        if (r_vec_idx == LAST_VEC) begin
          w_state_next = StFin;
          w_done_next  = 1'b1;
          // PASS must reflect the compare made on this very edge.
          w_pass_next  = (w_err_next == 3'd0);
          w_a_next     = 1'b0;
          w_b_next     = 1'b0;
        end else begin
          w_state_next         = StDrive;
          w_vec_next           = r_vec_idx + 2'd1;
          {w_a_next, w_b_next} = r_vec_idx + 2'd1;
          w_hold_load          = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

`ifdef GATE_CHK_FAILMAP_EN
  logic [3:0] r_fail_map, w_fail_map_next;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_fail_map <= 4'd0;
    end else begin
      r_fail_map <= w_fail_map_next;
    end
  end

  always_comb begin
    w_fail_map_next = r_fail_map;
    if (w_start_sweep) begin
      w_fail_map_next = 4'd0;
    end else if (w_mismatch) begin
      w_fail_map_next[r_vec_idx] = 1'b1;
    end
  end

  assign FAIL_MAP = r_fail_map;
`else
  assign FAIL_MAP = 4'd0;
`endif

  assign A       = r_a;
  assign B       = r_b;
  assign BUSY    = (r_state == StDrive) || (r_state == StSample);
  assign DONE    = r_done;
  assign PASS    = r_pass;
  assign ERR_CNT = r_err_cnt;
  assign VEC_IDX = r_vec_idx;

endmodule
